reg_file: RTL

- Architectural register file with rename tags: 32 x 32-bit registers, each with a busy bit and the ROB id of its pending producer.
- Downstream of the reorder buffer's commit port, which writes committed values. Also takes rename requests that the ROB forwards from issue.
- Serves the decoder's two source-operand lookups with ROB forwarding and a same-cycle commit bypass.
- Discards all rename state when the ROB flushes.

---
 rtl/reg_file_if.sv | 44 ++++
 rtl/reg_file.sv | 89 ++++++++
 2 files changed

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - commit, rename, operand read and ROB forwarding signals of the register file
interface reg_file_if #(
  parameter int ROB_W = 4
);
  // Commit from the ROB head
  logic [4:0]       set_id;
  logic [31:0]      set_val;
  logic [ROB_W-1:0] set_from_rob_id;
  // Rename forwarded from issue
  logic [4:0]       set_dep_id;
  logic [ROB_W-1:0] set_dep_Q;
  // Decoder source operand 1
  logic [4:0]       get_reg_1;
  logic [31:0]      get_val_1;
  logic             get_has_dep_1;
  logic [ROB_W-1:0] get_dep_1;
  logic [ROB_W-1:0] get_rob_id_1;
  logic             rob_avail_1;
  logic [31:0]      rob_val_1;
  // Decoder source operand 2
  logic [4:0]       get_reg_2;
  logic [31:0]      get_val_2;
  logic             get_has_dep_2;
  logic [ROB_W-1:0] get_dep_2;
  logic [ROB_W-1:0] get_rob_id_2;
  logic             rob_avail_2;
  logic [31:0]      rob_val_2;

  modport master (
    output set_id, set_val, set_from_rob_id, set_dep_id, set_dep_Q,
    output get_reg_1, rob_avail_1, rob_val_1,
    output get_reg_2, rob_avail_2, rob_val_2,
    input  get_val_1, get_has_dep_1, get_dep_1, get_rob_id_1,
    input  get_val_2, get_has_dep_2, get_dep_2, get_rob_id_2
  );

  modport slave (
    input  set_id, set_val, set_from_rob_id, set_dep_id, set_dep_Q,
    input  get_reg_1, rob_avail_1, rob_val_1,
    input  get_reg_2, rob_avail_2, rob_val_2,
    output get_val_1, get_has_dep_1, get_dep_1, get_rob_id_1,
    output get_val_2, get_has_dep_2, get_dep_2, get_rob_id_2
  );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file with rename tags, commit bypass and ROB forwarding
module reg_file #(
  parameter int ROB_W = 4,
  parameter int REG_N = 32
) (
  input logic     clk_in,
  input logic     rst_in,
  input logic     rdy_in,
  input logic     rob_clear,
  reg_file_if.slave bus
);

  logic [31:0]      val_q  [REG_N];
  logic             busy_q [REG_N];
  logic [ROB_W-1:0] tag_q  [REG_N];

  // Commit writes the value; rename (or flush) then overrides busy/tag, so later assignments win
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < REG_N; i++) begin
        val_q[i]  <= '0;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (bus.set_id != 5'd0) begin
        val_q[bus.set_id] <= bus.set_val;
        // A mismatching tag means a younger rename owns the register; keep it pending
        if (busy_q[bus.set_id] && (tag_q[bus.set_id] == bus.set_from_rob_id)) begin
          busy_q[bus.set_id] <= 1'b0;
        end
      end
      if (rob_clear) begin
        for (int i = 0; i < REG_N; i++) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end
      end else if (bus.set_dep_id != 5'd0) begin
        busy_q[bus.set_dep_id] <= 1'b1;
        tag_q[bus.set_dep_id]  <= bus.set_dep_Q;
      end
    end
  end

  // ROB lookup ids follow the tag regardless of busy so the ROB can be probed speculatively
  always_comb begin
    bus.get_rob_id_1 = tag_q[bus.get_reg_1];
    bus.get_rob_id_2 = tag_q[bus.get_reg_2];
  end

  // Source 1: x0, then architectural value, then same-cycle commit, then ROB forward, else pending
  always_comb begin
    bus.get_val_1     = '0;
    bus.get_has_dep_1 = 1'b0;
    bus.get_dep_1     = '0;
    if (bus.get_reg_1 == 5'd0) begin
      bus.get_val_1 = '0;
    end else if (!busy_q[bus.get_reg_1]) begin
      bus.get_val_1 = val_q[bus.get_reg_1];
    end else if ((bus.set_id == bus.get_reg_1) && (tag_q[bus.get_reg_1] == bus.set_from_rob_id)) begin
      bus.get_val_1 = bus.set_val;
    end else if (bus.rob_avail_1) begin
      bus.get_val_1 = bus.rob_val_1;
    end else begin
      bus.get_has_dep_1 = 1'b1;
      bus.get_dep_1     = tag_q[bus.get_reg_1];
    end
  end

  // Source 2: same priority as source 1
  always_comb begin
    bus.get_val_2     = '0;
    bus.get_has_dep_2 = 1'b0;
    bus.get_dep_2     = '0;
    if (bus.get_reg_2 == 5'd0) begin
      bus.get_val_2 = '0;
    end else if (!busy_q[bus.get_reg_2]) begin
      bus.get_val_2 = val_q[bus.get_reg_2];
    end else if ((bus.set_id == bus.get_reg_2) && (tag_q[bus.get_reg_2] == bus.set_from_rob_id)) begin
      bus.get_val_2 = bus.set_val;
    end else if (bus.rob_avail_2) begin
      bus.get_val_2 = bus.rob_val_2;
    end else begin
      bus.get_has_dep_2 = 1'b1;
      bus.get_dep_2     = tag_q[bus.get_reg_2];
    end
  end

endmodule
